// File: rtl/nor_mis_stim_gen.sv
// Stimulus sequencer for the NOR multiple-input-switching delay chain:
// issues N rise/fall pairs on myinA1/myinA2 with a cycle-exact lead/lag skew.
module nor_mis_stim_gen #(
    parameter int CNT_W = 8,
    parameter int REP_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             lead_sel,
    input  logic [CNT_W-1:0] skew_cyc,
    input  logic [CNT_W-1:0] hold_cyc,
    input  logic [REP_W-1:0] num_pairs,
    output logic             myinA1,
    output logic             myinA2,
    output logic             busy,
    output logic             done,
    output logic [REP_W-1:0] pair_cnt
);

    typedef enum logic [2:0] {
        IDLE, RISE_LEAD, LAG_HI, BOTH_HI, LAG_LO, BOTH_LO, FINISH
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             lead_lat;
    logic [CNT_W-1:0] s_lat;
    logic [CNT_W-1:0] h_lat;
    logic [REP_W-1:0] n_lat;
    logic             skew_zero;
    logic             last_pair;

    assign skew_zero = (s_lat == '0);
    assign last_pair = (pair_cnt == n_lat - REP_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            lead_lat <= 1'b0;
            s_lat    <= '0;
            h_lat    <= '0;
            n_lat    <= '0;
            myinA1   <= 1'b0;
            myinA2   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pair_cnt <= '0;
        end else begin
            done <= 1'b0;
            if (state != IDLE && abort) begin
                state  <= IDLE;
                myinA1 <= 1'b0;
                myinA2 <= 1'b0;
                busy   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        myinA1 <= 1'b0;
                        myinA2 <= 1'b0;
                        if (start) begin
                            lead_lat <= lead_sel;
                            s_lat    <= skew_cyc;
                            h_lat    <= hold_cyc;
                            n_lat    <= num_pairs;
                            pair_cnt <= '0;
                            if (num_pairs == '0) begin
                                done <= 1'b1;
                            end else begin
                                busy  <= 1'b1;
                                state <= RISE_LEAD;
                            end
                        end
                    end
                    // BOTH_LO expiry performs the rise itself so the pair period stays 2S+2H+2.
                    RISE_LEAD, BOTH_LO: begin
                        if (state == RISE_LEAD || cnt == '0) begin
                            if (lead_lat) myinA2 <= 1'b1;
                            else          myinA1 <= 1'b1;
                            if (skew_zero) begin
                                myinA1 <= 1'b1;
                                myinA2 <= 1'b1;
                                state  <= BOTH_HI;
                                cnt    <= h_lat;
                            end else begin
                                state <= LAG_HI;
                                cnt   <= s_lat - CNT_W'(1);
                            end
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                    LAG_HI: begin
                        if (cnt == '0) begin
                            if (lead_lat) myinA1 <= 1'b1;
                            else          myinA2 <= 1'b1;
                            state <= BOTH_HI;
                            cnt   <= h_lat;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                    BOTH_HI: begin
                        if (cnt == '0) begin
                            if (lead_lat) myinA2 <= 1'b0;
                            else          myinA1 <= 1'b0;
                            if (skew_zero) begin
                                myinA1   <= 1'b0;
                                myinA2   <= 1'b0;
                                pair_cnt <= pair_cnt + REP_W'(1);
                                state    <= last_pair ? FINISH : BOTH_LO;
                                cnt      <= h_lat;
                            end else begin
                                state <= LAG_LO;
                                cnt   <= s_lat - CNT_W'(1);
                            end
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                    LAG_LO: begin
                        if (cnt == '0) begin
                            if (lead_lat) myinA1 <= 1'b0;
                            else          myinA2 <= 1'b0;
                            pair_cnt <= pair_cnt + REP_W'(1);
                            state    <= last_pair ? FINISH : BOTH_LO;
                            cnt      <= h_lat;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                    FINISH: begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_nor_mis_stim_gen.sv
// Scoreboard bench for nor_mis_stim_gen: expected per-cycle pin values come
// from the closed-form pair timing and are popped by an independent monitor.
module tb_nor_mis_stim_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        lead_sel = 1'b0;
    logic [7:0]  skew_cyc = '0;
    logic [7:0]  hold_cyc = '0;
    logic [15:0] num_pairs = '0;
    logic        myinA1, myinA2, busy, done;
    logic [15:0] pair_cnt;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic        a1;
        logic        a2;
        logic        busy;
        logic        done;
        logic [15:0] pc;
    } exp_t;

    exp_t q[$];

    nor_mis_stim_gen #(.CNT_W(8), .REP_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .lead_sel(lead_sel), .skew_cyc(skew_cyc), .hold_cyc(hold_cyc),
        .num_pairs(num_pairs), .myinA1(myinA1), .myinA2(myinA2),
        .busy(busy), .done(done), .pair_cnt(pair_cnt)
    );

    always #5 clk = ~clk;

    // Pairs completed after relative edge t (t = 0 is the first leader rise).
    function automatic int pc_at(int s, int h, int n, int t);
        int p, c;
        p = 2*s + 2*h + 2;
        if (t < 2*s + h + 1) return 0;
        c = (t - (2*s + h + 1)) / p + 1;
        return (c > n) ? n : c;
    endfunction

    // Expected pins after edge E0+j; abort_j > 0 means abort asserted at edge E0+abort_j.
    function automatic exp_t model(int s, int h, int n, int lead, int j, int abort_j);
        exp_t e;
        int t, p, r, tend;
        logic ld, lg;
        e = '0;
        if (n == 0) begin
            e.done = (j == 0);
            return e;
        end
        if (abort_j > 0 && j >= abort_j) begin
            e.pc = 16'(pc_at(s, h, n, abort_j - 2));
            return e;
        end
        if (j == 0) begin
            e.busy = 1'b1;
            return e;
        end
        t    = j - 1;
        p    = 2*s + 2*h + 2;
        tend = (n - 1) * p + 2*s + h + 2;
        if (t < tend) begin
            e.busy = 1'b1;
            r  = t % p;
            ld = (r < s + h + 1);
            lg = (r >= s) && (r < 2*s + h + 1);
            e.a1 = lead ? lg : ld;
            e.a2 = lead ? ld : lg;
        end else begin
            e.done = (t == tend);
        end
        e.pc = 16'(pc_at(s, h, n, t));
        return e;
    endfunction

    always @(posedge clk) begin
        exp_t e, a;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            a = '{a1: myinA1, a2: myinA2, busy: busy, done: done, pc: pair_cnt};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL pins t=%0t: got a1=%b a2=%b busy=%b done=%b pc=%0d, want a1=%b a2=%b busy=%b done=%b pc=%0d",
                         $time, a.a1, a.a2, a.busy, a.done, a.pc, e.a1, e.a2, e.busy, e.done, e.pc);
            end
        end
    end

    task automatic drain();
        int guard;
        guard = 0;
        while (q.size() > 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (q.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL drain: got %0d entries left, want 0", q.size());
            q.delete();
        end
    endtask

    task automatic run_seq(int s, int h, int n, int lead, int abort_j);
        int tend, total, busy_until;
        tend  = (n - 1) * (2*s + 2*h + 2) + 2*s + h + 2;
        total = (n == 0) ? 2 : ((abort_j > 0) ? abort_j + 1 : tend + 3);
        busy_until = (n == 0) ? 0 : ((abort_j > 0) ? abort_j : tend + 1);
        @(negedge clk);
        skew_cyc  = 8'(s);
        hold_cyc  = 8'(h);
        num_pairs = 16'(n);
        lead_sel  = lead[0];
        start     = 1'b1;
        abort     = 1'($urandom_range(0, 1));
        q.push_back(model(s, h, n, lead, 0, abort_j));
        for (int j = 1; j < total; j++) begin
            @(negedge clk);
            q.push_back(model(s, h, n, lead, j, abort_j));
            if (j < busy_until) begin
                // Start and config churn while running must not disturb the sequence.
                start     = 1'($urandom_range(0, 1));
                skew_cyc  = 8'($urandom);
                hold_cyc  = 8'($urandom);
                num_pairs = 16'($urandom_range(0, 5));
                lead_sel  = 1'($urandom_range(0, 1));
                abort     = (j == abort_j);
            end else if (j == busy_until && abort_j > 0) begin
                start = 1'($urandom_range(0, 1));
                abort = 1'b1;
            end else begin
                start = 1'b0;
                abort = (j > busy_until) ? 1'($urandom_range(0, 1)) : 1'b0;
            end
        end
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        drain();
    endtask

    task automatic check_direct(string name, logic [3:0] got, logic [3:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %b, want %b", name, got, want);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_direct("reset_state", {myinA1, myinA2, busy, done}, 4'b0000);
        checks++;
        if (pair_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_pair_cnt: got %0d, want 0", pair_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;

        run_seq(0, 0, 1, 0, 0);
        run_seq(3, 2, 2, 1, 0);
        run_seq(0, 0, 0, 0, 0);
        run_seq(5, 1, 0, 1, 0);
        run_seq(2, 3, 3, 0, 17);          // abort inside BOTH_HI of pair 1
        run_seq(0, 0, 65535, 1, 50);      // maximum N, cut short by abort
        run_seq(0, 4, 3, 1, 0);
        run_seq(1, 0, 2, 0, 0);

        for (int i = 0; i < 24; i++) begin
            int s, h, n, ab;
            s = $urandom_range(0, 6);
            h = $urandom_range(0, 6);
            n = $urandom_range(0, 4);
            ab = 0;
            if (n > 0 && $urandom_range(0, 3) == 0)
                ab = $urandom_range(1, (n - 1) * (2*s + 2*h + 2) + 2*s + h + 2);
            run_seq(s, h, n, $urandom_range(0, 1), ab);
        end

        // Asynchronous reset in the middle of LAG_HI at maximum skew and hold.
        @(negedge clk);
        skew_cyc  = 8'd255;
        hold_cyc  = 8'd255;
        num_pairs = 16'd2;
        lead_sel  = 1'b0;
        start     = 1'b1;
        q.push_back(model(255, 255, 2, 0, 0, 0));
        for (int j = 1; j <= 100; j++) begin
            @(negedge clk);
            q.push_back(model(255, 255, 2, 0, j, 0));
            start = 1'b0;
        end
        @(negedge clk);
        q.delete();
        check_direct("pre_reset_lead_high", {myinA1, myinA2, busy, done}, 4'b1010);
        #2 rst_n = 1'b0;
        #1;
        check_direct("async_reset", {myinA1, myinA2, busy, done}, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        run_seq(255, 255, 2, 0, 0);
        run_seq(255, 255, 1, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
